// File: rtl/mult_issue_arbiter.sv
// Issue arbiter sharing the FP multiply/descale pipeline among NUM_REQ requesters, with result routing and flush/drain.
// Optional MULT_ARB_PRIO0_EN: requester 0 gets fixed top priority; the others round-robin behind it.
module mult_issue_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*33-1:0] req_a,
  input  logic [NUM_REQ*33-1:0] req_b,
  input  logic [NUM_REQ*32-1:0] req_z,
  input  logic [NUM_REQ-1:0]    req_scale_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  flush,
  output logic [32:0]           issue_a,
  output logic [32:0]           issue_b,
  output logic [31:0]           issue_z,
  output logic                  issue_scale_valid,
  output logic                  issue_idle,
  output logic [7:0]            issue_tag,
  output logic [NUM_REQ-1:0]    res_valid,
  output logic [7:0]            res_tag,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t             state_r, state_next_s;
  logic [1:0]         rr_ptr_r, rr_ptr_next_s;
  logic [5:0]         seq_r [NUM_REQ];
  logic               grant_s, inflight_s, seq_clr_s;
  logic [1:0]         grant_id_s;
  int                 best_s, dist_s, ptr_s;
  logic [32:0]        sel_a_s, sel_b_s;
  logic [31:0]        sel_z_s;
  logic               sel_sv_s;
  logic [5:0]         sel_seq_s;
  logic [NUM_REQ-1:0] issue_hot_s;
  logic [NUM_REQ-1:0] sr_hot_r [PIPE_LAT];
  logic [7:0]         sr_tag_r [PIPE_LAT];

  // Pick the closest valid requester at or after the rr pointer; nothing while flushing or draining.
  always_comb begin
    grant_s       = 1'b0;
    grant_id_s    = 2'd0;
    best_s        = NUM_REQ;
    dist_s        = 0;
    ptr_s         = int'(rr_ptr_r);
    rr_ptr_next_s = rr_ptr_r;
    if (state_r != DRAIN && !flush) begin
`ifdef MULT_ARB_PRIO0_EN
      if (ptr_s == 0) begin
        ptr_s = 1;
      end else begin
        ptr_s = ptr_s;
      end
      for (int i = 1; i < NUM_REQ; i++) begin
        dist_s = (i >= ptr_s) ? (i - ptr_s) : (i - ptr_s + NUM_REQ - 1);
        if (req_valid[i] && dist_s < best_s) begin
          best_s     = dist_s;
          grant_s    = 1'b1;
          grant_id_s = 2'(i);
        end else begin
          best_s = best_s;
        end
      end
      if (req_valid[0]) begin
        grant_s    = 1'b1;
        grant_id_s = 2'd0;
      end else begin
        grant_s = grant_s;
      end
      // Grants to requester 0 leave the pointer alone so it never points at 0.
      if (grant_s && grant_id_s != 2'd0) begin
        rr_ptr_next_s = (int'(grant_id_s) == NUM_REQ - 1) ? 2'd1 : grant_id_s + 2'd1;
      end else begin
        rr_ptr_next_s = rr_ptr_r;
      end
`else
      for (int i = 0; i < NUM_REQ; i++) begin
        dist_s = (i >= ptr_s) ? (i - ptr_s) : (i - ptr_s + NUM_REQ);
        if (req_valid[i] && dist_s < best_s) begin
          best_s     = dist_s;
          grant_s    = 1'b1;
          grant_id_s = 2'(i);
        end else begin
          best_s = best_s;
        end
      end
      if (grant_s) begin
        rr_ptr_next_s = 2'((int'(grant_id_s) + 1) % NUM_REQ);
      end else begin
        rr_ptr_next_s = rr_ptr_r;
      end
`endif
    end else begin
      grant_s = 1'b0;
    end
    req_ready = NUM_REQ'(grant_s) << grant_id_s;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a_s   = 33'd0;
    sel_b_s   = 33'd0;
    sel_z_s   = 32'd0;
    sel_sv_s  = 1'b0;
    sel_seq_s = 6'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a_s   = sel_a_s   | (req_a[i*33 +: 33] & {33{grant_id_s == 2'(i)}});
      sel_b_s   = sel_b_s   | (req_b[i*33 +: 33] & {33{grant_id_s == 2'(i)}});
      sel_z_s   = sel_z_s   | (req_z[i*32 +: 32] & {32{grant_id_s == 2'(i)}});
      sel_sv_s  = sel_sv_s  | (req_scale_valid[i] & (grant_id_s == 2'(i)));
      sel_seq_s = sel_seq_s | (seq_r[i] & {6{grant_id_s == 2'(i)}});
    end
  end

  // The op delivering in the last stage this cycle no longer counts as in flight.
  always_comb begin
    inflight_s = !issue_idle;
    for (int s = 0; s < PIPE_LAT - 1; s++) begin
      inflight_s = inflight_s | (|sr_hot_r[s]);
    end
  end

  // Next-state logic; leaving DRAIN restarts every sequence counter.
  always_comb begin
    state_next_s = state_r;
    seq_clr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_next_s = DRAIN;
        end else if (grant_s) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_next_s = DRAIN;
        end else if (!inflight_s && !grant_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        if (!flush && !inflight_s) begin
          state_next_s = IDLE;
          seq_clr_s    = 1'b1;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, rr pointer, busy and per-requester sequence counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      rr_ptr_r <= 2'd0;
      busy     <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) seq_r[i] <= 6'd0;
    end else begin
      state_r  <= state_next_s;
      rr_ptr_r <= rr_ptr_next_s;
      busy     <= (state_next_s != IDLE);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (seq_clr_s) begin
          seq_r[i] <= 6'd0;
        end else if (grant_s && grant_id_s == 2'(i)) begin
          seq_r[i] <= seq_r[i] + 6'd1;
        end else begin
          seq_r[i] <= seq_r[i];
        end
      end
    end
  end

  // Issue registers; data holds across bubbles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issue_a           <= 33'd0;
      issue_b           <= 33'd0;
      issue_z           <= 32'd0;
      issue_scale_valid <= 1'b0;
      issue_idle        <= 1'b1;
      issue_tag         <= 8'd0;
    end else if (grant_s) begin
      issue_a           <= sel_a_s;
      issue_b           <= sel_b_s;
      issue_z           <= sel_z_s;
      issue_scale_valid <= sel_sv_s;
      issue_idle        <= 1'b0;
      issue_tag         <= {grant_id_s, sel_seq_s};
    end else begin
      issue_idle        <= 1'b1;
    end
  end

  assign issue_hot_s = issue_idle ? '0 : (NUM_REQ'(1) << issue_tag[7:6]);

  // Latency tracker: one-hot owner plus tag, shifted once per cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < PIPE_LAT; s++) begin
        sr_hot_r[s] <= '0;
        sr_tag_r[s] <= 8'd0;
      end
    end else begin
      sr_hot_r[0] <= issue_hot_s;
      sr_tag_r[0] <= issue_tag;
      for (int s = 1; s < PIPE_LAT; s++) begin
        sr_hot_r[s] <= sr_hot_r[s-1];
        sr_tag_r[s] <= sr_tag_r[s-1];
      end
    end
  end

  assign res_valid = sr_hot_r[PIPE_LAT-1];
  assign res_tag   = sr_tag_r[PIPE_LAT-1];
endmodule

// File: tb/tb_mult_issue_arbiter.sv
// Self-checking bench for mult_issue_arbiter against a queue-based reference model.
module tb_mult_issue_arbiter;
  localparam int NR = 4;
  localparam int PL = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [NR-1:0]    req_valid = '0, req_scale_valid = '0, req_ready;
  logic [NR*33-1:0] req_a = '0, req_b = '0;
  logic [NR*32-1:0] req_z = '0;
  logic             flush = 1'b0;
  logic [32:0]      issue_a, issue_b;
  logic [31:0]      issue_z;
  logic             issue_scale_valid, issue_idle, busy;
  logic [7:0]       issue_tag, res_tag;
  logic [NR-1:0]    res_valid;

  mult_issue_arbiter #(.NUM_REQ(NR), .PIPE_LAT(PL)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_z(req_z), .req_scale_valid(req_scale_valid), .req_ready(req_ready), .flush(flush),
    .issue_a(issue_a), .issue_b(issue_b), .issue_z(issue_z), .issue_scale_valid(issue_scale_valid),
    .issue_idle(issue_idle), .issue_tag(issue_tag), .res_valid(res_valid), .res_tag(res_tag), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {int due; int id; logic [7:0] tag;} op_t;
  op_t pend[$];
  int  m_ptr, m_seq[NR], cyc, n_tests, n_fail;
  bit  m_drain;
  logic [NR-1:0] obs_ready;
  logic obs_busy_pre;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int model_pick(input logic [NR-1:0] v, input logic f);
    if (m_drain || f) return -1;
`ifdef MULT_ARB_PRIO0_EN
    if (v[0]) return 0;
    for (int j = 0; j < NR - 1; j++) begin
      int i = 1 + (((m_ptr == 0) ? 0 : m_ptr - 1) + j) % (NR - 1);
      if (v[i]) return i;
    end
`else
    for (int j = 0; j < NR; j++) begin
      int i = (m_ptr + j) % NR;
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic bit later_ops(input int c);
    foreach (pend[k]) if (pend[k].due > c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    pend.delete();
    m_ptr = 0; m_drain = 1'b0;
    for (int i = 0; i < NR; i++) m_seq[i] = 0;
  endtask

  // One clock of stimulus with full comparison against the reference model.
  task automatic cycle(input logic [NR-1:0] v, input logic f, input bit rnd);
    int g; logic [32:0] ea, eb; logic [31:0] ez; logic es; logic [7:0] etag, rtag;
    logic [NR-1:0] eready, ehot; bit busy_exp;
    ea = '0; eb = '0; ez = '0; es = 1'b0; etag = '0; rtag = '0;
    @(negedge clock);
    req_valid = v; flush = f;
    if (rnd) for (int i = 0; i < NR; i++) begin
      req_a[i*33 +: 33] = {1'($urandom), 32'($urandom)};
      req_b[i*33 +: 33] = {1'($urandom), 32'($urandom)};
      req_z[i*32 +: 32] = 32'($urandom);
      req_scale_valid[i] = 1'($urandom);
    end
    #1;
    g = model_pick(v, f);
    eready = (g < 0) ? '0 : (NR'(1) << g);
    obs_ready = req_ready; obs_busy_pre = busy;
    n_tests++;
    if (req_ready !== eready) begin
      n_fail++; $display("FAIL ready: got %b want %b (cycle %0d)", req_ready, eready, cyc);
    end
    if (g >= 0) begin
      ea = req_a[g*33 +: 33]; eb = req_b[g*33 +: 33]; ez = req_z[g*32 +: 32];
      es = req_scale_valid[g]; etag = {2'(g), 6'(m_seq[g])};
    end
    if (!m_drain) begin
      if (f) m_drain = 1'b1;
    end else if (!f && !later_ops(cyc)) begin
      m_drain = 1'b0;
      for (int i = 0; i < NR; i++) m_seq[i] = 0;
    end
    @(posedge clock); #1;
    if (g >= 0) begin
      pend.push_back('{cyc + PL, g, etag});
      m_seq[g] = (m_seq[g] + 1) % 64;
`ifdef MULT_ARB_PRIO0_EN
      if (g != 0) m_ptr = (g == NR - 1) ? 1 : g + 1;
`else
      m_ptr = (g + 1) % NR;
`endif
    end
    n_tests++;
    if (issue_idle !== (g < 0)) begin
      n_fail++; $display("FAIL issue_idle: got %b want %b (cycle %0d)", issue_idle, (g < 0), cyc);
    end
    if (g >= 0) begin
      n_tests++;
      if ({issue_tag, issue_a, issue_b, issue_z, issue_scale_valid} !== {etag, ea, eb, ez, es}) begin
        n_fail++; $display("FAIL issue_data: got tag %h a %h b %h z %h sv %b want tag %h a %h b %h z %h sv %b",
                           issue_tag, issue_a, issue_b, issue_z, issue_scale_valid, etag, ea, eb, ez, es);
      end
    end
    busy_exp = m_drain || (pend.size() > 0);
    ehot = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ehot = NR'(1) << pend[0].id; rtag = pend[0].tag; void'(pend.pop_front());
    end
    n_tests++;
    if (res_valid !== ehot) begin
      n_fail++; $display("FAIL res_valid: got %b want %b (cycle %0d)", res_valid, ehot, cyc);
    end
    if (ehot != '0) begin
      n_tests++;
      if (res_tag !== rtag) begin
        n_fail++; $display("FAIL res_tag: got %h want %h", res_tag, rtag);
      end
    end
    n_tests++;
    if (busy !== busy_exp) begin
      n_fail++; $display("FAIL busy: got %b want %b (cycle %0d)", busy, busy_exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; req_valid = '0; flush = 1'b0;
    #1;
    n_tests++;
    if ({issue_idle, issue_a, issue_b, issue_z, issue_scale_valid, issue_tag, res_tag, res_valid, busy, req_ready}
        !== {1'b1, 33'd0, 33'd0, 32'd0, 1'b0, 8'd0, 8'd0, {NR{1'b0}}, 1'b0, {NR{1'b0}}}) begin
      n_fail++; $display("FAIL reset_values: got idle %b a %h tag %h rtag %h res %b busy %b ready %b want 1/0/0/0/0/0/0",
                         issue_idle, issue_a, issue_tag, res_tag, res_valid, busy, req_ready);
    end
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) cycle(4'hF, 1'b0, 1'b1);
    do_reset();
    for (int k = 0; k < 2 * PL; k++) begin
      cycle('0, 1'b0, 1'b0);
      n_tests++;
      if (res_valid !== '0) begin
        n_fail++; $display("FAIL res_after_reset: got %b want 0000", res_valid);
      end
    end
  endtask

  task automatic test_single();
    logic [32:0] a, b;
    do_reset();
    a = {1'b0, 8'h7F, 24'h800000}; b = {1'b0, 8'h80, 24'hC00000};
    req_a[2*33 +: 33] = a; req_b[2*33 +: 33] = b;
    cycle(4'b0100, 1'b0, 1'b0);
    n_tests++;
    if (obs_ready !== 4'b0100 || issue_idle !== 1'b0 || issue_tag !== 8'h80 || issue_a !== a || issue_b !== b) begin
      n_fail++; $display("FAIL single_issue: got ready %b idle %b tag %h a %h want 0100 0 80 %h", obs_ready, issue_idle, issue_tag, issue_a, a);
    end
    for (int k = 0; k < PL; k++) cycle('0, 1'b0, 1'b0);
    n_tests++;
    if (res_valid !== 4'b0100 || res_tag !== 8'h80) begin
      n_fail++; $display("FAIL single_result: got %b/%h want 0100/80", res_valid, res_tag);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_tags [8];
    exp_tags = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h01, 8'h41, 8'h81, 8'hC1};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(4'hF, 1'b0, 1'b1);
      n_tests++;
      if (issue_tag !== exp_tags[k]) begin
        n_fail++; $display("FAIL fairness[%0d]: got tag %h want %h", k, issue_tag, exp_tags[k]);
      end
    end
    for (int k = 0; k < PL + 1; k++) cycle('0, 1'b0, 1'b0);
  endtask

  task automatic test_seq_wrap();
    do_reset();
    for (int n = 1; n <= 65; n++) begin
      cycle(4'b0010, 1'b0, 1'b1);
      if (n == 64 || n == 65) begin
        n_tests++;
        if (issue_tag !== ((n == 64) ? 8'h7F : 8'h40)) begin
          n_fail++; $display("FAIL seq_wrap op%0d: got tag %h want %h", n, issue_tag, (n == 64) ? 8'h7F : 8'h40);
        end
      end
    end
    for (int k = 0; k < PL + 1; k++) cycle('0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    int nres, seen;
    bit done;
    do_reset();
    cycle(4'hF, 1'b0, 1'b1);
    cycle(4'hF, 1'b0, 1'b1);
    cycle(4'hF, 1'b1, 1'b1);
    n_tests++;
    if (obs_ready !== '0) begin
      n_fail++; $display("FAIL flush_ready: got %b want 0000", obs_ready);
    end
    nres = (res_valid != '0) ? 1 : 0;
    done = 1'b0; seen = 0;
    for (int k = 0; k < 4 * PL && !done; k++) begin
      cycle(4'hF, 1'b0, 1'b1);
      if (obs_ready != '0) begin
        done = 1'b1;
        n_tests++;
        if (obs_busy_pre !== 1'b0) begin
          n_fail++; $display("FAIL flush_idle_busy: got %b want 0", obs_busy_pre);
        end
      end else begin
        nres += (res_valid != '0) ? 1 : 0;
      end
    end
    n_tests++;
    if (!done || nres != 2) begin
      n_fail++; $display("FAIL flush_drain: got done %0d results %0d want 1 2", done, nres);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cycle(4'hF, 1'b0, 1'b1);
      n_tests++;
      if (issue_tag[5:0] !== 6'd0) begin
        n_fail++; $display("FAIL flush_seq_restart: got tag %h want seq 00", issue_tag);
      end
      seen++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      cycle(NR'($urandom), ($urandom_range(0, 19) == 0), 1'b1);
    end
    for (int k = 0; k < PL + 2; k++) cycle('0, 1'b0, 1'b0);
  endtask

`ifdef MULT_ARB_PRIO0_EN
  task automatic test_prio0();
    int exp_id [4];
    exp_id = '{1, 2, 3, 1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(4'hF, 1'b0, 1'b1);
      n_tests++;
      if (issue_tag[7:6] !== 2'd0) begin
        n_fail++; $display("FAIL prio0_hold: got id %0d want 0", issue_tag[7:6]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      cycle(4'hE, 1'b0, 1'b1);
      n_tests++;
      if (int'(issue_tag[7:6]) != exp_id[k]) begin
        n_fail++; $display("FAIL prio0_rr[%0d]: got id %0d want %0d", k, issue_tag[7:6], exp_id[k]);
      end
    end
  endtask
`endif

  initial begin
    cyc = 0; n_tests = 0; n_fail = 0;
    model_clear();
    test_reset();
    test_single();
`ifdef MULT_ARB_PRIO0_EN
    test_prio0();
`else
    test_fairness();
`endif
    test_seq_wrap();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_issue_arbiter.md
Name: mult_issue_arbiter

Overview:
- Shares the single floating-point multiply/descale pipeline between NUM_REQ requesters, e.g. CORDIC x/y descale paths and the generic multiply path.
- Round-robin grant over valid/ready requests; issues one operand pair per cycle into the special-case/multiply stage inputs and generates InsTag.
- Tracks in-flight operations in a latency shift register and routes a one-hot result strobe back to the owning requester.
- Supports a flush/drain sequence.

Parameters:
- NUM_REQ, 4, number of requesters; legal values 2 or 4.
- PIPE_LAT, 4, cycles from issue to result at the multiply-pipeline tail; range 1..15.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_a  in  NUM_REQ*33  operand a per requester, {sign, exp[7:0], mant[23:0]}; requester i at bits [33i+32:33i]
- req_b  in  NUM_REQ*33  operand b, same packing as req_a
- req_z  in  NUM_REQ*32  passthrough z word per requester
- req_scale_valid  in  NUM_REQ  passthrough ScaleValid flag per requester
- req_ready  out  NUM_REQ  combinational grant; transfer occurs when valid&ready
- flush  in  1  stop issuing and drain the pipeline
- issue_a  out  33  operand a to pipeline
- issue_b  out  33  operand b to pipeline
- issue_z  out  32  z to pipeline
- issue_scale_valid  out  1  ScaleValid to pipeline
- issue_idle  out  1  1 = bubble (put_idle), 0 = live op (no_idle)
- issue_tag  out  8  InsTag = {id[1:0], seq[5:0]}; id zero-extended when NUM_REQ=2
- res_valid  out  NUM_REQ  one-hot result strobe, 1 cycle
- res_tag  out  8  tag of the returning op
- busy  out  1  any op in flight, or state != IDLE

Behaviour:
- Reset (async, reset_n=0):
  - issue_idle=1; issue_a, issue_b, issue_z, issue_tag, res_tag = 0; issue_scale_valid=0; res_valid=0; busy=0.
  - rr pointer=0; all seq counters=0; shift register empty; state=IDLE.
  - Reset mid-operation discards all in-flight tracking; no res_valid fires afterwards.
- States:
  - IDLE: no op in flight, nothing granted this cycle.
  - RUN: shift register non-empty or a grant is made.
  - DRAIN: flush seen; waiting for the shift register to empty.
- Transitions:
  - IDLE->RUN on any grant.
  - RUN->IDLE when the shift register is empty and there is no grant.
  - IDLE/RUN->DRAIN when flush=1.
  - DRAIN->IDLE when the shift register is empty and flush=0.
  - While in DRAIN with flush still high, stay in DRAIN.
- Grant:
  - In IDLE/RUN, req_ready is one-hot: the first asserted req_valid at or after the rr pointer, wrapping modulo NUM_REQ.
  - req_ready=0 in DRAIN, and in any cycle where flush=1.
  - On a grant to requester i, rr pointer <= (i+1) mod NUM_REQ.
  - With no grant, the pointer holds.
- Issue, at the edge after a grant to i:
  - issue_a/b/z/scale_valid <= requester i fields; issue_idle <= 0; issue_tag <= {i, seq[i]}; seq[i] <= seq[i]+1, wrapping 63->0.
  - With no grant: issue_idle <= 1; data outputs hold their previous values.
- Tracking and result timing:
  - Shift register depth PIPE_LAT, each entry {valid, id, tag}, loaded from the issue registers.
  - An op with issue_idle=0 in cycle k has res_valid[id]=1 and res_tag=tag in cycle k+PIPE_LAT.
  - Back-to-back issues produce back-to-back results in issue order.
  - In-flight ops still return during DRAIN.
- Drain completion: on the DRAIN->IDLE transition, all seq counters clear to 0.
- busy = (state != IDLE).
- Throughput: 1 op/cycle sustained; no stall input, because the pipeline never back-pressures.

Optional Feature:
- Macro MULT_ARB_PRIO0_EN.
- Defined: requester 0 has fixed highest priority; the remaining requesters are round-robin among themselves only when req_valid[0]=0, and the rr pointer skips 0.
- Undefined: pure round-robin as specified in Behaviour.

Test Plan:
- Reset: reset_n low mid-stream with 3 ops in flight -> outputs at reset values immediately; no res_valid within the next 2*PIPE_LAT cycles.
- Single op: req_valid=4'b0100 with a=0x0_7F_800000, b=0x0_80_C00000 -> req_ready=0100 same cycle; next cycle issue_idle=0, issue_tag=0x80; PIPE_LAT cycles later res_valid=0100, res_tag=0x80.
- Fairness: all four req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3; tags 0x00,0x40,0x80,0xC0,0x01,0x41,0x81,0xC1.
- Seq wrap: requester 1 issues 65 ops -> the 64th op carries tag 0x7F, the 65th carries tag 0x40.
- Flush: assert flush for 1 cycle with 2 ops in flight and req_valid=1111 -> req_ready=0 in the flush cycle and through DRAIN; both results return; then IDLE, busy=0, next tag per requester is seq 0.
- MULT_ARB_PRIO0_EN: req_valid=1111 held -> grants 0,0,0...; drop req_valid[0] -> grants 1,2,3,1.
